// File: rtl/sprite_rom_arbiter.sv
// Burst-locked round-robin arbiter sharing one synchronous sprite ROM between two renderers.
// Define SPRITE_ROM_ARB_STATS_EN to add per-requester grant counters and their clear input.

`ifdef SPRITE_ROM_ARB_STATS_EN
// Saturating 16-bit event counter; a synchronous clear beats a same-cycle increment.
module sprite_rom_arb_cnt (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] cnt
);
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset)                         cnt <= '0;
        else if (clr)                      cnt <= '0;
        else if (inc && cnt != 16'hFFFF)   cnt <= cnt + 16'd1;
    end
endmodule
`endif

module sprite_rom_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 4,
    parameter int ROM_LAT   = 1,
    parameter int BURST_LEN = 4
) (
    input  logic              vga_clk,
    input  logic              reset,
`ifdef SPRITE_ROM_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [15:0]       gnt_cnt0,
    output logic [15:0]       gnt_cnt1,
`endif
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q
);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam logic [BEAT_W-1:0] BURST_MAX = BEAT_W'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t            state, state_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic              last, last_nxt;
    logic              gnt_any, gnt_id, cont;
    logic              own_id, own_req, oth_req;

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        cont    = 1'b0;
        own_id  = (state == OWN1);
        own_req = own_id ? req1 : req0;
        oth_req = own_id ? req0 : req1;
        case (state)
            OWN0, OWN1: begin
                if (own_req && beat < BURST_MAX) begin
                    gnt_any = 1'b1;
                    gnt_id  = own_id;
                    cont    = 1'b1;
                end else if (oth_req) begin
                    gnt_any = 1'b1;
                    gnt_id  = ~own_id;
                end else if (own_req) begin
                    // burst exhausted but nobody else waiting: start a fresh burst
                    gnt_any = 1'b1;
                    gnt_id  = own_id;
                end
            end
            default: begin
                if (req0 && req1) begin
                    gnt_any = 1'b1;
                    gnt_id  = ~last;
                end else if (req0 || req1) begin
                    gnt_any = 1'b1;
                    gnt_id  = req1;
                end
            end
        endcase
    end

    always_comb begin
        state_nxt = IDLE;
        beat_nxt  = '0;
        last_nxt  = last;
        if (gnt_any) begin
            state_nxt = gnt_id ? OWN1 : OWN0;
            beat_nxt  = cont ? beat + 1'b1 : BEAT_W'(1);
            last_nxt  = gnt_id;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            beat  <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            last  <= last_nxt;
        end
    end

    // Reset is asynchronous, so the combinational grant must be masked as well.
    assign gnt0        = gnt_any & ~gnt_id & ~reset;
    assign gnt1        = gnt_any &  gnt_id & ~reset;
    assign rom_address = gnt0 ? addr0 : (gnt1 ? addr1 : '0);

    // Response tracking: {valid,id} travels alongside the ROM's own latency.
    logic [ROM_LAT:1] vld_pipe;
    logic [ROM_LAT:1] id_pipe;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[1] <= gnt0 | gnt1;
            id_pipe[1]  <= gnt1;
            for (int i = 2; i <= ROM_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                id_pipe[i]  <= id_pipe[i-1];
            end
        end
    end

    assign rvalid0 = vld_pipe[ROM_LAT] & ~id_pipe[ROM_LAT];
    assign rvalid1 = vld_pipe[ROM_LAT] &  id_pipe[ROM_LAT];
    assign rdata   = rom_q;

`ifdef SPRITE_ROM_ARB_STATS_EN
    logic [1:0][15:0] cnt_arr;

    sprite_rom_arb_cnt u_cnt [1:0] (
        .vga_clk (vga_clk),
        .reset   (reset),
        .clr     (stats_clr),
        .inc     ({gnt1, gnt0}),
        .cnt     (cnt_arr)
    );

    assign gnt_cnt0 = cnt_arr[0];
    assign gnt_cnt1 = cnt_arr[1];
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized self-checking bench for sprite_rom_arbiter against a grant/response reference model.
module tb_sprite_rom_arbiter;
    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 4;
    localparam int ROM_LAT   = 2;
    localparam int BURST_LEN = 4;

    logic              vga_clk = 1'b0;
    logic              reset   = 1'b1;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata, rom_q;
    logic [ADDR_W-1:0] rom_address;
`ifdef SPRITE_ROM_ARB_STATS_EN
    logic              stats_clr = 1'b0;
    logic [15:0]       gnt_cnt0, gnt_cnt1;
`endif

    sprite_rom_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .BURST_LEN(BURST_LEN)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
`ifdef SPRITE_ROM_ARB_STATS_EN
        .stats_clr   (stats_clr),
        .gnt_cnt0    (gnt_cnt0),
        .gnt_cnt1    (gnt_cnt1),
`endif
        .req0        (req0),
        .req1        (req1),
        .addr0       (addr0),
        .addr1       (addr1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .rvalid0     (rvalid0),
        .rvalid1     (rvalid1),
        .rdata       (rdata),
        .rom_address (rom_address),
        .rom_q       (rom_q)
    );

    always #5 vga_clk = ~vga_clk;

    function automatic logic [DATA_W-1:0] rom_val(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] h;
        h = a ^ (a >> 4) ^ (a >> 7) ^ 10'h2B5;
        return h[DATA_W-1:0];
    endfunction

    // ROM model with ROM_LAT cycles of read latency
    logic [DATA_W-1:0] rom_pipe [ROM_LAT];
    always @(posedge vga_clk) begin
        rom_pipe[0] <= rom_val(rom_address);
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = rom_pipe[ROM_LAT-1];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner (-1 = nobody), length of current run, last granted id,
    // expected responses in flight (oldest at ROM_LAT-1), grant counters.
    int                m_owner, m_run, m_last;
    int                ep_id  [ROM_LAT];
    logic [DATA_W-1:0] ep_dat [ROM_LAT];
    int                m_cnt [2];

    function automatic void model_reset();
        m_owner = -1;
        m_run   = 0;
        m_last  = 1;
        for (int i = 0; i < ROM_LAT; i++) begin
            ep_id[i]  = -1;
            ep_dat[i] = '0;
        end
        m_cnt[0] = 0;
        m_cnt[1] = 0;
    endfunction

    task automatic cyc(input bit r0, input bit r1,
                       input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                       input bit clr);
        bit rq [2];
        int g;
        bit cont;
        logic [ADDR_W-1:0] ea;
        @(negedge vga_clk);
        req0 = r0; req1 = r1; addr0 = a0; addr1 = a1;
`ifdef SPRITE_ROM_ARB_STATS_EN
        stats_clr = clr;
`endif
        #1;
        rq[0] = r0; rq[1] = r1;
        g = -1; cont = 0;
        if (m_owner >= 0) begin
            if (rq[m_owner] && m_run < BURST_LEN) begin g = m_owner; cont = 1; end
            else if (rq[1-m_owner])               g = 1 - m_owner;
            else if (rq[m_owner])                 g = m_owner;
        end else begin
            if (r0 && r1)  g = 1 - m_last;
            else if (r0)   g = 0;
            else if (r1)   g = 1;
        end
        ea = (g == 0) ? a0 : (g == 1) ? a1 : '0;
        chk("gnt0", 32'(gnt0), 32'(g == 0));
        chk("gnt1", 32'(gnt1), 32'(g == 1));
        chk("rom_address", 32'(rom_address), 32'(ea));
        chk("rvalid0", 32'(rvalid0), 32'(ep_id[ROM_LAT-1] == 0));
        chk("rvalid1", 32'(rvalid1), 32'(ep_id[ROM_LAT-1] == 1));
        if (ep_id[ROM_LAT-1] >= 0) chk("rdata", 32'(rdata), 32'(ep_dat[ROM_LAT-1]));
`ifdef SPRITE_ROM_ARB_STATS_EN
        chk("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt[0]));
        chk("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt[1]));
        for (int n = 0; n < 2; n++) begin
            if (clr)                          m_cnt[n] = 0;
            else if (g == n && m_cnt[n] < 65535) m_cnt[n]++;
        end
`endif
        m_run   = cont ? m_run + 1 : 1;
        m_owner = g;
        if (g >= 0) m_last = g;
        for (int i = ROM_LAT - 1; i > 0; i--) begin
            ep_id[i]  = ep_id[i-1];
            ep_dat[i] = ep_dat[i-1];
        end
        ep_id[0]  = g;
        ep_dat[0] = rom_val(ea);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_gnt0"}, 32'(gnt0), 32'd0);
        chk({tag, "_gnt1"}, 32'(gnt1), 32'd0);
        chk({tag, "_rvalid0"}, 32'(rvalid0), 32'd0);
        chk({tag, "_rvalid1"}, 32'(rvalid1), 32'd0);
        chk({tag, "_rom_address"}, 32'(rom_address), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'(rom_q));
`ifdef SPRITE_ROM_ARB_STATS_EN
        chk({tag, "_cnt0"}, 32'(gnt_cnt0), 32'd0);
        chk({tag, "_cnt1"}, 32'(gnt_cnt1), 32'd0);
`endif
    endtask

    // Reset asserted mid-cycle with both requests high; release on a later negedge.
    task automatic do_reset();
        @(negedge vga_clk);
        #2;
        reset = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 10'h1A3; addr1 = 10'h2C4;
        #1;
        reset_checks("rst_a");
        @(negedge vga_clk);
        #1;
        reset_checks("rst_b");
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();
        cyc(0, 0, '0, '0, 0);

        // single read from requester 0
        cyc(1, 0, 10'h005, 10'h3FF, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, '0, 0);

        // both requesting: bursts of BURST_LEN alternate
        for (int i = 0; i < 14; i++) cyc(1, 1, ADDR_W'(i), ADDR_W'(100 + i), 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0, 0);

        // requester 0 alone: burst restarts without a bubble
        for (int i = 0; i < 10; i++) cyc(1, 0, ADDR_W'(200 + i), '0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0, 0);

        // mid-burst handover when the owner drops and the other raises
        cyc(1, 0, 10'h010, '0, 0);
        cyc(1, 0, 10'h011, '0, 0);
        cyc(0, 1, '0, 10'h020, 0);
        cyc(1, 1, 10'h012, 10'h021, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0, 0);

        // random traffic with varying request density
        for (int i = 0; i < 800; i++) begin
            int p0, p1;
            p0 = (i / 200) + 1;
            p1 = 4 - (i / 200);
            cyc($urandom_range(0, 4) < p0, $urandom_range(0, 4) < p1,
                ADDR_W'($urandom), ADDR_W'($urandom), 0);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0, 0);

        // read in flight is dropped by reset; requester 0 wins first afterwards
        cyc(1, 0, 10'h0AB, '0, 0);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 0, '0, '0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 1, 10'h033, 10'h044, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0, 0);

`ifdef SPRITE_ROM_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 0, ADDR_W'(i), '0, 0);
        cyc(1, 0, 10'h007, '0, 1);
        cyc(0, 0, '0, '0, 0);
        cyc(0, 1, '0, 10'h008, 0);
        cyc(0, 0, '0, '0, 0);
        // drive requester 0 past saturation
        for (int i = 0; i < 65540; i++) cyc(1, 0, ADDR_W'(i), '0, 0);
        cyc(0, 0, '0, '0, 0);
        cyc(0, 0, '0, '0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
